// File: rtl/sram_1rw_masked_init.sv
// Parametrised 1RW SRAM model with per-lane write mask, clear-on-reset init sequencer,
// held registered read data with valid strobe, and out-of-range error pulse.
module sram_1rw_masked_init #(
    parameter int                   DEPTH    = 128,
    parameter int                   ADDR_W   = 7,
    parameter int                   DATA_W   = 36,
    parameter int                   LANE_W   = 9,
    parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
    input  logic                       RW0_clk,
    input  logic                       RW0_rst_n,
    input  logic [ADDR_W-1:0]          RW0_addr,
    input  logic                       RW0_en,
    input  logic                       RW0_wmode,
    input  logic [DATA_W/LANE_W-1:0]   RW0_wmask,
    input  logic [DATA_W-1:0]          RW0_wdata,
    output logic                       RW0_ready,
    output logic [DATA_W-1:0]          RW0_rdata,
    output logic                       RW0_rvalid,
    output logic                       RW0_err
);

    localparam int                MASK_W    = DATA_W / LANE_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   init_ptr_q, init_ptr_d;
    logic                ready_q, ready_d;
    logic                rvalid_q, rvalid_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                in_range;
    logic                accepted;
    logic                init_we;
    logic                wr_we;

    always_comb begin
        in_range   = ({1'b0, RW0_addr} < DEPTH_EXT);
        accepted   = RW0_en & ready_q;
        // Memory writes are suppressed on a reset edge so reset itself never touches contents.
        init_we    = RW0_rst_n & (state_q == S_INIT);
        wr_we      = RW0_rst_n & accepted & RW0_wmode & in_range;

        state_d    = state_q;
        init_ptr_d = init_ptr_q;
        ready_d    = ready_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_INIT: begin
                if (init_ptr_q == LAST_ADDR) begin
                    state_d = S_RUN;
                    ready_d = 1'b1;
                end else begin
                    init_ptr_d = init_ptr_q + ADDR_W'(1);
                end
            end
            S_RUN: begin
                if (accepted) begin
                    err_d = ~in_range;
                    if (!RW0_wmode) begin
                        rvalid_d = 1'b1;
                        rdata_d  = in_range ? mem_q[RW0_addr] : '0;
                    end
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge RW0_clk) begin
        if (!RW0_rst_n) begin
            state_q    <= S_INIT;
            init_ptr_q <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_ptr_q <= init_ptr_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge RW0_clk) begin
        if (init_we) begin
            mem_q[init_ptr_q] <= INIT_VAL;
        end else if (wr_we) begin
            for (int i = 0; i < MASK_W; i++) begin
                if (RW0_wmask[i]) begin
                    mem_q[RW0_addr][i*LANE_W +: LANE_W] <= RW0_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    assign RW0_ready  = ready_q;
    assign RW0_rdata  = rdata_q;
    assign RW0_rvalid = rvalid_q;
    assign RW0_err    = err_q;

endmodule

// File: tb/tb_sram_1rw_masked_init.sv
// Bench for sram_1rw_masked_init: a full-size instance (DEPTH=128) and a DEPTH=100 instance
// with nonzero INIT_VAL; read results and error pulses are checked against a scoreboard.
module tb_sram_1rw_masked_init;

    localparam logic [35:0] INIT1 = 36'h1_2345_6789;

    typedef struct {
        int          cyc;
        logic [35:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          armed = 1'b0;

    logic        en0 = 1'b0, wm0 = 1'b0;
    logic [6:0]  ad0 = '0;
    logic [3:0]  mk0 = '0;
    logic [35:0] wd0 = '0;
    logic        ready0, rvalid0, err0;
    logic [35:0] rdata0;

    logic        en1 = 1'b0, wm1 = 1'b0;
    logic [6:0]  ad1 = '0;
    logic [3:0]  mk1 = '0;
    logic [35:0] wd1 = '0;
    logic        ready1, rvalid1, err1;
    logic [35:0] rdata1;

    logic [35:0] model0 [128];
    logic [35:0] model1 [128];
    exp_t        rq0[$], rq1[$];
    int          eq0[$], eq1[$];
    exp_t        pop0, pop1;

    sram_1rw_masked_init #(
        .DEPTH(128), .ADDR_W(7), .DATA_W(36), .LANE_W(9), .INIT_VAL(36'h0)
    ) u_dut0 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(ad0), .RW0_en(en0),
        .RW0_wmode(wm0), .RW0_wmask(mk0), .RW0_wdata(wd0), .RW0_ready(ready0),
        .RW0_rdata(rdata0), .RW0_rvalid(rvalid0), .RW0_err(err0)
    );

    sram_1rw_masked_init #(
        .DEPTH(100), .ADDR_W(7), .DATA_W(36), .LANE_W(9), .INIT_VAL(INIT1)
    ) u_dut1 (
        .RW0_clk(clk), .RW0_rst_n(rst_n), .RW0_addr(ad1), .RW0_en(en1),
        .RW0_wmode(wm1), .RW0_wmask(mk1), .RW0_wdata(wd1), .RW0_ready(ready1),
        .RW0_rdata(rdata1), .RW0_rvalid(rvalid1), .RW0_err(err1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each expected read result / error pulse is due on a specific cycle.
    always @(negedge clk) begin
        if (armed) begin
            n_chk++;
            if (rq0.size() != 0 && rq0[0].cyc == cyc) begin
                pop0 = rq0.pop_front();
                if (rvalid0 !== 1'b1 || rdata0 !== pop0.data) begin
                    n_fail++;
                    $display("FAIL read0 cyc %0d: rvalid=%b rdata=%h, want rvalid=1 rdata=%h",
                             cyc, rvalid0, rdata0, pop0.data);
                end
            end else if (rvalid0 !== 1'b0) begin
                n_fail++;
                $display("FAIL rvalid0_spurious cyc %0d: rvalid=%b want 0", cyc, rvalid0);
            end
            n_chk++;
            if (rq1.size() != 0 && rq1[0].cyc == cyc) begin
                pop1 = rq1.pop_front();
                if (rvalid1 !== 1'b1 || rdata1 !== pop1.data) begin
                    n_fail++;
                    $display("FAIL read1 cyc %0d: rvalid=%b rdata=%h, want rvalid=1 rdata=%h",
                             cyc, rvalid1, rdata1, pop1.data);
                end
            end else if (rvalid1 !== 1'b0) begin
                n_fail++;
                $display("FAIL rvalid1_spurious cyc %0d: rvalid=%b want 0", cyc, rvalid1);
            end
            n_chk++;
            if (eq0.size() != 0 && eq0[0] == cyc) begin
                void'(eq0.pop_front());
                if (err0 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err0 cyc %0d: err=%b want 1", cyc, err0);
                end
            end else if (err0 !== 1'b0) begin
                n_fail++;
                $display("FAIL err0_spurious cyc %0d: err=%b want 0", cyc, err0);
            end
            n_chk++;
            if (eq1.size() != 0 && eq1[0] == cyc) begin
                void'(eq1.pop_front());
                if (err1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL err1 cyc %0d: err=%b want 1", cyc, err1);
                end
            end else if (err1 !== 1'b0) begin
                n_fail++;
                $display("FAIL err1_spurious cyc %0d: err=%b want 0", cyc, err1);
            end
        end
    end

    // One accepted access on instance u; expectations are queued at issue time.
    task automatic access(input int u, input bit w, input int a, input logic [3:0] m,
                          input logic [35:0] d);
        exp_t e;
        int   depth;
        depth = (u == 0) ? 128 : 100;
        e.cyc = cyc + 1;
        if (u == 0) begin
            en0 = 1'b1; wm0 = w; ad0 = a[6:0]; mk0 = m; wd0 = d;
        end else begin
            en1 = 1'b1; wm1 = w; ad1 = a[6:0]; mk1 = m; wd1 = d;
        end
        if (a >= depth) begin
            if (u == 0) eq0.push_back(cyc + 1);
            else        eq1.push_back(cyc + 1);
        end
        if (w) begin
            if (a < depth) begin
                for (int i = 0; i < 4; i++) begin
                    if (m[i]) begin
                        if (u == 0) model0[a][i*9 +: 9] = d[i*9 +: 9];
                        else        model1[a][i*9 +: 9] = d[i*9 +: 9];
                    end
                end
            end
        end else begin
            if (a >= depth)  e.data = 36'h0;
            else if (u == 0) e.data = model0[a];
            else             e.data = model1[a];
            if (u == 0) rq0.push_back(e);
            else        rq1.push_back(e);
        end
        @(posedge clk); #1;
        if (u == 0) en0 = 1'b0;
        else        en1 = 1'b0;
    endtask

    // Releases reset and measures cycles until ready; optionally pokes a write during INIT.
    task automatic release_and_wait(input bit poke);
        int k0, k1;
        k0 = 0;
        k1 = 0;
        if (poke) begin
            en0 = 1'b1; wm0 = 1'b1; ad0 = 7'd3; mk0 = 4'hF; wd0 = '1;
            en1 = 1'b1; wm1 = 1'b1; ad1 = 7'd3; mk1 = 4'hF; wd1 = '1;
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 300 && (k0 == 0 || k1 == 0); k++) begin
            @(posedge clk); #1;
            if (ready1 === 1'b1 && k1 == 0) begin k1 = k; en1 = 1'b0; end
            if (ready0 === 1'b1 && k0 == 0) begin k0 = k; en0 = 1'b0; end
        end
        en0 = 1'b0;
        en1 = 1'b0;
        n_chk++;
        if (k0 != 128) begin
            n_fail++;
            $display("FAIL ready0_latency: got %0d cycles want 128 (0 = never)", k0);
        end
        n_chk++;
        if (k1 != 100) begin
            n_fail++;
            $display("FAIL ready1_latency: got %0d cycles want 100 (0 = never)", k1);
        end
        for (int i = 0; i < 128; i++) begin
            model0[i] = 36'h0;
            model1[i] = INIT1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (ready0 !== 1'b0 || rvalid0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 36'h0) begin
            n_fail++;
            $display("FAIL reset0: ready=%b rvalid=%b err=%b rdata=%h want 0 0 0 0",
                     ready0, rvalid0, err0, rdata0);
        end
        n_chk++;
        if (ready1 !== 1'b0 || rvalid1 !== 1'b0 || err1 !== 1'b0 || rdata1 !== 36'h0) begin
            n_fail++;
            $display("FAIL reset1: ready=%b rvalid=%b err=%b rdata=%h want 0 0 0 0",
                     ready1, rvalid1, err1, rdata1);
        end
        armed = 1'b1;
        release_and_wait(1'b1);
    endtask

    task automatic test_init_ignores_en();
        access(0, 1'b0, 3, 4'h0, 36'h0);
        access(1, 1'b0, 3, 4'h0, 36'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_init_readback();
        for (int a = 0; a < 128; a++) access(0, 1'b0, a, 4'h0, 36'h0);
        for (int a = 0; a < 100; a++) access(1, 1'b0, a, 4'h0, 36'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_lane_mask();
        access(0, 1'b1, 5, 4'b1111, 36'hF_FFFF_FFFF);
        access(0, 1'b1, 5, 4'b0101, 36'h0);
        access(0, 1'b0, 5, 4'h0, 36'h0);
        access(0, 1'b1, 6, 4'b1010, 36'hA_BCDE_F012);
        access(0, 1'b1, 6, 4'b0000, 36'hF_FFFF_FFFF);
        access(0, 1'b0, 6, 4'h0, 36'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        logic [35:0] held;
        access(0, 1'b1, 9, 4'hF, 36'h9_8765_4321);
        access(0, 1'b0, 9, 4'h0, 36'h0);
        held = model0[9];
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_chk++;
            if (rvalid0 !== 1'b0 || rdata0 !== held) begin
                n_fail++;
                $display("FAIL hold_idle%0d: rvalid=%b rdata=%h want 0 %h", i, rvalid0, rdata0, held);
            end
        end
        access(0, 1'b1, 9, 4'hF, 36'h1_1111_1111);
        n_chk++;
        if (rvalid0 !== 1'b0 || rdata0 !== held) begin
            n_fail++;
            $display("FAIL hold_write: rvalid=%b rdata=%h want 0 %h", rvalid0, rdata0, held);
        end
        access(0, 1'b0, 9, 4'h0, 36'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        access(1, 1'b1, 100, 4'hF, 36'hD_EAD_BEEF0);
        access(1, 1'b0, 127, 4'h0, 36'h0);
        access(1, 1'b0, 99, 4'h0, 36'h0);
        access(1, 1'b1, 99, 4'b0011, 36'h0_0000_ABCD);
        access(1, 1'b0, 100, 4'h0, 36'h0);
        access(1, 1'b0, 99, 4'h0, 36'h0);
        access(1, 1'b0, 36, 4'h0, 36'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [63:0] r;
        for (int i = 0; i < 80; i++) begin
            r = {$urandom, $urandom};
            access(0, bit'($urandom_range(0, 1)), $urandom_range(0, 7),
                   4'($urandom_range(0, 15)), r[35:0]);
        end
        for (int a = 0; a < 8; a++) access(0, 1'b0, a, 4'h0, 36'h0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] r;
        for (int a = 0; a < 128; a++) begin
            r = {$urandom, $urandom};
            access(0, 1'b1, a, 4'hF, r[35:0] | 36'h1);
        end
        for (int a = 0; a < 40; a++) access(0, 1'b0, a, 4'h0, 36'h0);
        en0 = 1'b1; wm0 = 1'b0; ad0 = 7'd40;
        rst_n = 1'b0;
        @(posedge clk); #1;
        en0 = 1'b0;
        n_chk++;
        if (rvalid0 !== 1'b0 || ready0 !== 1'b0 || rdata0 !== 36'h0) begin
            n_fail++;
            $display("FAIL midreset: rvalid=%b ready=%b rdata=%h want 0 0 0", rvalid0, ready0, rdata0);
        end
        @(posedge clk); #1;
        release_and_wait(1'b0);
        for (int a = 0; a < 128; a++) access(0, 1'b0, a, 4'h0, 36'h0);
        for (int a = 0; a < 100; a += 11) access(1, 1'b0, a, 4'h0, 36'h0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_init_ignores_en();
        test_init_readback();
        test_lane_mask();
        test_hold();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_burst();
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (rq0.size() + rq1.size() + eq0.size() + eq1.size() != 0) begin
            n_fail++;
            $display("FAIL pending: %0d expectations never matched, want 0",
                     rq0.size() + rq1.size() + eq0.size() + eq1.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, want completion");
        $fatal(1, "watchdog");
    end

endmodule
